// File: rtl/riscv_defines.sv
// Shared definitions for the iterative divider: op-field bit positions and FSM state type.
package riscv_defines;

  localparam int unsigned DIV_OP_SIGNED_BIT = 0;
  localparam int unsigned DIV_OP_REM_BIT    = 1;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_FINISH
  } div_state_t;

endpackage

// File: rtl/riscv_div_clz.sv
// 32-bit leading-zero counter; an all-zero input reports 32.
module riscv_div_clz (
  input  logic [31:0] i_data,
  output logic [5:0]  o_count
);

  // Scanning LSB to MSB lets the highest set bit win.
  always_comb begin
    o_count = 6'd32;
    for (int i = 0; i < 32; i++) begin
      if (i_data[i]) begin
        o_count = 6'(31 - i);
      end
    end
  end

endmodule

// File: rtl/riscv_iter_divider.sv
// Radix-2 restoring divider for DIVU/DIV/REMU/REM with valid/ready on both sides.
// Optional RISCV_DIV_EARLY_TERM_EN skips leading zeros of |dividend| to shorten latency.
module riscv_iter_divider
  import riscv_defines::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] result_o
);

  div_state_t  r_state, w_state_d;
  logic [1:0]  r_op, w_op_d;
  logic        r_sign_a, w_sign_a_d;
  logic        r_sign_b, w_sign_b_d;
  logic        r_div_zero, w_div_zero_d;
  logic [31:0] r_quot, w_quot_d;
  logic [31:0] r_divisor, w_divisor_d;
  // The partial remainder always stays below the divisor, so 32 stored bits are exact;
  // the 33rd bit only exists transiently in the shifted/trial values.
  logic [31:0] r_rem, w_rem_d;
  logic [5:0]  r_cnt, w_cnt_d;

  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_shift, w_trial;
  logic [31:0] w_quot_load;
  logic [5:0]  w_cnt_load;
  logic [31:0] w_quot_res, w_rem_src, w_rem_res;

  assign w_abs_a = (op_i[DIV_OP_SIGNED_BIT] && dividend_i[31]) ? (~dividend_i + 32'd1)
                                                                : dividend_i;
  assign w_abs_b = (op_i[DIV_OP_SIGNED_BIT] && divisor_i[31]) ? (~divisor_i + 32'd1)
                                                               : divisor_i;

  assign w_shift = {r_rem, r_quot[31]};
  assign w_trial = w_shift - {1'b0, r_divisor};

`ifdef RISCV_DIV_EARLY_TERM_EN
  logic [5:0] w_lz;

  riscv_div_clz u_clz (
    .i_data  (w_abs_a),
    .o_count (w_lz)
  );

  assign w_quot_load = w_abs_a << w_lz;
  assign w_cnt_load  = 6'd32 - w_lz;
`else
  assign w_quot_load = w_abs_a;
  assign w_cnt_load  = 6'd32;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_op_d       = r_op;
    w_sign_a_d   = r_sign_a;
    w_sign_b_d   = r_sign_b;
    w_div_zero_d = r_div_zero;
    w_quot_d     = r_quot;
    w_divisor_d  = r_divisor;
    w_rem_d      = r_rem;
    w_cnt_d      = r_cnt;

    if (flush_i) begin
      w_state_d = DIV_IDLE;
    end else begin
      unique case (r_state)
        DIV_IDLE: begin
          if (valid_i) begin
            w_op_d       = op_i;
            w_sign_a_d   = op_i[DIV_OP_SIGNED_BIT] & dividend_i[31];
            w_sign_b_d   = op_i[DIV_OP_SIGNED_BIT] & divisor_i[31];
            w_divisor_d  = w_abs_b;
            w_rem_d      = '0;
            w_cnt_d      = w_cnt_load;
            w_div_zero_d = (divisor_i == '0);
            if (divisor_i == '0) begin
              // Keep |dividend| unshifted: it becomes the divide-by-zero remainder.
              w_quot_d  = w_abs_a;
              w_state_d = DIV_FINISH;
            end else if (w_cnt_load == 6'd0) begin
              w_quot_d  = '0;
              w_state_d = DIV_FINISH;
            end else begin
              w_quot_d  = w_quot_load;
              w_state_d = DIV_BUSY;
            end
          end
        end
        DIV_BUSY: begin
          w_rem_d  = w_trial[32] ? w_shift[31:0] : w_trial[31:0];
          w_quot_d = {r_quot[30:0], ~w_trial[32]};
          w_cnt_d  = r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            w_state_d = DIV_FINISH;
          end
        end
        DIV_FINISH: begin
          if (ready_i) begin
            w_state_d = DIV_IDLE;
          end
        end
        default: begin
          w_state_d = DIV_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= DIV_IDLE;
      r_op       <= '0;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_div_zero <= 1'b0;
      r_quot     <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
      r_cnt      <= '0;
    end else begin
      r_state    <= w_state_d;
      r_op       <= w_op_d;
      r_sign_a   <= w_sign_a_d;
      r_sign_b   <= w_sign_b_d;
      r_div_zero <= w_div_zero_d;
      r_quot     <= w_quot_d;
      r_divisor  <= w_divisor_d;
      r_rem      <= w_rem_d;
      r_cnt      <= w_cnt_d;
    end
  end

  // Sign fix-up; signed overflow (MIN / -1) needs no special case since -MIN == MIN.
  assign w_quot_res = r_div_zero            ? 32'hFFFF_FFFF :
                      (r_sign_a ^ r_sign_b) ? (~r_quot + 32'd1) : r_quot;
  assign w_rem_src  = r_div_zero ? r_quot : r_rem;
  assign w_rem_res  = r_sign_a ? (~w_rem_src + 32'd1) : w_rem_src;

  assign result_o = r_op[DIV_OP_REM_BIT] ? w_rem_res : w_quot_res;
  assign ready_o  = (r_state == DIV_IDLE);
  assign valid_o  = (r_state == DIV_FINISH);

endmodule

// File: doc/riscv_iter_divider.md
# riscv_iter_divider

Multi-cycle radix-2 restoring integer divider for the RI5CY execute stage. It consumes the div/rem operations selected by the ALU operator field (ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM) and returns a 32-bit quotient or remainder to the EX/WB result mux. Operations enter and leave through a valid/ready handshake, so the ID stage stalls while a division is in flight.

## Interface

- `DATA_WIDTH`, default 32: operand and result width. Only 32 is supported.
- `clk` in, 1: core clock, rising edge.
- `rst` in, 1: reset. Synchronous, active-high; one clock; reset is synchronous and active-high.
- `flush_i` in, 1: abort the in-flight operation and drop any unconsumed result.
- `valid_i` in, 1: an operation is offered.
- `ready_o` out, 1: divider is IDLE and accepts an operation.
- `op_i` in, 2: low two bits of the ALU operator. Bit 0 = signed, bit 1 = remainder.
- `dividend_i` in, 32: operand a (rs1).
- `divisor_i` in, 32: operand b (rs2).
- `valid_o` out, 1: `result_o` is valid.
- `ready_i` in, 1: the consumer accepts the result.
- `result_o` out, 32: quotient (bit1=0) or remainder (bit1=1).

## Operation

- State machine `IDLE -> DIV -> FINISH -> IDLE`.
- IDLE
  - `ready_o` = 1.
  - On `valid_i`:
    - Latch `op_i`.
    - Latch the operand signs, only when bit0 = 1.
    - Latch |dividend| into the quotient/shift register and |divisor| into the divisor register.
    - Clear the 33-bit partial remainder.
    - Load the iteration counter with 32.
  - If divisor == 0, go straight to FINISH. Otherwise go to DIV.
- DIV, one bit per cycle:
  - Shift {rem, quot} left by 1.
  - trial = rem − divisor, computed 33 bits wide.
  - If trial ≥ 0: rem = trial and the new quotient LSB = 1. Otherwise restore, and the LSB = 0.
  - The counter decrements. When it reaches 0, go to FINISH.
- FINISH
  - `valid_o` = 1.
  - `result_o` is combinational from the registers.
  - Quotient is negated when signed and the operand signs differ.
  - Remainder takes the sign of the dividend.
  - On `ready_i`, go to IDLE.
- Divide by zero (RISC-V semantics):
  - Quotient = 0xFFFFFFFF for both signed and unsigned.
  - Remainder = the original dividend, unmodified.
- Signed overflow, 0x80000000 / 0xFFFFFFFF:
  - Falls out naturally: quotient 0x80000000, remainder 0.
  - No special-case logic is needed.
- `flush_i` has priority over every other input. From any state it goes to IDLE at the next edge. `valid_o` deasserts that edge. An operation offered in the same cycle as the flush is not accepted.
- `rst` has the same effect as `flush_i`, and also clears all datapath registers.

## Timing

- Reset values: `ready_o` = 1, `valid_o` = 0, `result_o` = 0 (state IDLE, registers zero).
- Accept happens on the edge where `valid_i && ready_o`.
- Normal latency:
  - 32 cycles in DIV.
  - `valid_o` rises 33 edges after the accept edge.
- Divide by zero: `valid_o` rises 1 edge after the accept edge.
- `result_o` is stable while `valid_o && !ready_i`. The result is held indefinitely.
- Back-to-back operation:
  - The next accept happens no earlier than the edge after the FINISH handshake.
  - `ready_o` is never asserted together with `valid_o`.
- No combinational path from `valid_i` to `ready_o`, or from `ready_i` to `valid_o`.

## Configuration

- `RISCV_DIV_EARLY_TERM_EN` defined:
  - In IDLE, count the leading zeros z of |dividend|.
  - Pre-shift the dividend left by z and load the counter with 32 − z.
  - Latency becomes (32 − z) + 1 edges.
  - Dividend == 0 goes directly to FINISH with quotient 0 and remainder 0, in 1 edge.
- Not defined: the fixed 32-iteration latency and no leading-zero hardware.
- Results are bit-identical in both builds.

## Structure

- In `riscv_defines`, add:
  - `DIV_OP_SIGNED_BIT` = 0 and `DIV_OP_REM_BIT` = 1.
  - `typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_FINISH} div_state_t`.
- Sub-module `riscv_div_clz`:
  - 32-bit leading-zero counter with a 6-bit output.
  - Instantiated only under `RISCV_DIV_EARLY_TERM_EN`.

## Test plan

- DIVU 100 / 7:
  - `result_o` = 14, with `valid_o` exactly 33 edges after accept in the non-early build.
  - REMU with the same operands → 2.
- DIV −7 / 2 → 0xFFFFFFFD (−3). REM −7 / 2 → 0xFFFFFFFF (−1). REM 7 / −2 → 1.
- Divide by zero, in both builds:
  - DIV 5 / 0 → 0xFFFFFFFF after 1 edge.
  - REM −5 / 0 → 0xFFFFFFFB.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM with the same operands → 0.
- Flush and backpressure:
  - Assert `flush_i` at iteration 10 → `ready_o` = 1 at the next edge, and `valid_o` never pulses.
  - Hold `ready_i` = 0 for 5 cycles in FINISH → `result_o` is constant.
  - Assert `rst` mid-DIV → IDLE and all outputs at their reset values.
- `RISCV_DIV_EARLY_TERM_EN`:
  - DIVU 3 / 1 → 3 after 3 edges.
  - DIVU 0 / 9 → 0 after 1 edge.
  - 10,000 random signed and unsigned operand pairs match the reference model in both builds.
